game_lives_ctrl: RTL and testbench
==================================

Name: game_lives_ctrl

Overview:
- Lives/loss supervisor that sits directly upstream of the game-start FSM and produces its loss input (`perdio`).
- Consumes player-hit and alien-invasion events from the collision logic, plus the game-running signal from the start FSM.
- Tracks remaining lives and applies a post-hit invulnerability window.
- On loss, holds `perdio` high for a fixed number of frames, then releases it so the start FSM can run its end/return sequence.

Parameters:
- W, 3, width of the lives counter; VIDAS_MAX = 2**W-1.
- VIDAS_INI, 3, lives loaded at game start; legal range 1..VIDAS_MAX.
- CNT_W, 8, width of the frame counter.
- INVULN_FRAMES, 60, frames of invulnerability after a non-fatal hit; legal range 1..2**CNT_W-1.
- PERDIO_FRAMES, 120, frames `perdio` stays high; legal range 1..2**CNT_W-1.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- juego_activo  in  1  game-running level from the start FSM.
- tick_frame  in  1  one-cycle pulse, once per video frame.
- impacto  in  1  one-cycle pulse: player ship hit.
- invasion  in  1  one-cycle pulse: aliens reached the bottom row; immediate loss.
- vida_extra  in  1  one-cycle pulse: score milestone (used only with VIDA_EXTRA_EN).
- vidas  out  W  remaining lives, for the HUD.
- invulnerable  out  1  high during the invulnerability window (ship blink, hit masking).
- perdio  out  1  loss flag to the start FSM.

Behaviour:
- General: all outputs are registered. No combinational path from any input to any output; every response appears one cycle after the triggering edge.
- Reset: state=IDLE, vidas=VIDAS_INI, cnt=0, invulnerable=0, perdio=0. Reset mid-game aborts immediately to these values.
- IDLE:
  - vidas held at VIDAS_INI.
  - juego_activo=1 -> JUGANDO.
- JUGANDO: events are evaluated in this priority order.
  1. juego_activo=0 -> IDLE.
  2. invasion -> vidas=0, cnt=PERDIO_FRAMES, go to PERDIDO.
  3. impacto with vidas==1 -> vidas=0, cnt=PERDIO_FRAMES, go to PERDIDO.
  4. impacto with vidas>1 -> vidas-1, cnt=INVULN_FRAMES, go to INVULN.
- INVULN:
  - invulnerable=1 for every cycle spent in this state.
  - impacto is ignored.
  - juego_activo=0 -> IDLE. Otherwise invasion -> PERDIDO as in JUGANDO.
  - On tick_frame, cnt decrements. If cnt==1 at that tick -> JUGANDO.
- PERDIDO:
  - perdio=1 for every cycle spent in this state.
  - Ignores impacto, invasion and juego_activo.
  - On tick_frame, cnt decrements. If cnt==1 at that tick -> FIN.
- FIN:
  - perdio=0, vidas holds 0.
  - juego_activo=0 -> IDLE.
  - A still-high juego_activo never restarts the game, so a stale run level cannot retrigger.
- Simultaneous events:
  - impacto and invasion in the same cycle: invasion wins; vidas goes to 0, not vidas-1.
  - impacto and tick_frame in the same cycle in JUGANDO: the hit is processed, and the tick is not counted against the new window.
- vidas never underflows below 0.
- The decrement on impacto uses the registered vidas value.

Optional Feature:
- Macro: VIDA_EXTRA_EN.
- Defined:
  - A vida_extra pulse in JUGANDO or INVULN increments vidas, saturating at VIDAS_MAX.
  - If it coincides with a non-fatal impacto, the net change to vidas is 0 and INVULN is still entered.
  - If it coincides with a fatal event (invasion, or impacto with vidas==1), the loss wins.
  - Ignored in all other states.
- Undefined: vida_extra is ignored entirely; the port remains declared so top-level wiring is identical.

Decomposition:
- Shared package game_pkg holds:
  - the state encoding IDLE/JUGANDO/INVULN/PERDIDO/FIN (3 bits);
  - default constants VIDAS_INI_DEF, INVULN_FRAMES_DEF, PERDIO_FRAMES_DEF.
- One sub-module, frame_down_counter:
  - loadable CNT_W-bit down counter, decrements on tick_frame;
  - asserts `done` when the count is 1 and a tick arrives;
  - shared by the INVULN and PERDIDO windows.

Test Plan:
- Reset, then juego_activo=1, then 3 impacto pulses, each spaced by 61 ticks -> vidas 3->2->1->0. invulnerable high for exactly 60 ticks after each of the first two hits. perdio rises on the cycle after the third hit.
- In INVULN, impacto at tick 10 -> vidas unchanged, and the window still ends exactly at tick 60.
- vidas=3, then invasion -> vidas=0 and perdio=1 next cycle. perdio stays high for exactly 120 ticks, then 0. Dropping juego_activo afterwards -> IDLE with vidas=3.
- impacto and invasion in the same cycle with vidas=2 -> vidas=0 and PERDIDO, not INVULN.
- RST asserted while in PERDIDO -> next cycle perdio=0, vidas=3, state IDLE, regardless of juego_activo.
- With VIDA_EXTRA_EN: vidas=7 plus vida_extra -> stays 7; vidas=2 plus vida_extra and impacto together -> vidas=2 and INVULN entered. Without the macro, the same stimulus gives vidas=1.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the lives/loss supervisor.
//   state_e            - supervisor states (3-bit encoding)
//   *_DEF              - default values for the game_lives_ctrl parameters
package game_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    JUGANDO = 3'd1,
    INVULN  = 3'd2,
    PERDIDO = 3'd3,
    FIN     = 3'd4
  } state_e;

  localparam int unsigned VIDAS_INI_DEF     = 3;
  localparam int unsigned INVULN_FRAMES_DEF = 60;
  localparam int unsigned PERDIO_FRAMES_DEF = 120;

endpackage

// File: rtl/frame_down_counter.sv
// frame_down_counter: loadable down counter clocked by frame ticks.
//   clk_i      - system clock
//   rst_i      - synchronous active-high reset (count -> 0)
//   load_i     - load load_val_i; wins over a coincident tick
//   load_val_i - value to load
//   tick_i     - one-cycle frame pulse; decrements a non-zero count
//   done_o     - tick arriving while the count is 1 (window expires)
module frame_down_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             tick_i,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A tick on the same cycle as a load belongs to the old window, not the new one.
  assign done_o = tick_i && !load_i && (cnt_q == ONE);

endmodule

// File: rtl/game_lives_ctrl.sv
// game_lives_ctrl: lives/loss supervisor feeding the game-start FSM.
//   CLK, RST      - clock, synchronous active-high reset
//   juego_activo  - game-running level from the start FSM
//   tick_frame    - one pulse per video frame
//   impacto       - player ship hit pulse
//   invasion      - aliens reached bottom row (immediate loss)
//   vida_extra    - score milestone pulse (effective only with VIDA_EXTRA_EN)
//   vidas         - remaining lives (registered)
//   invulnerable  - post-hit invulnerability window (registered)
//   perdio        - loss flag, held for PERDIO_FRAMES frames (registered)
// Build option: define VIDA_EXTRA_EN to enable extra lives on vida_extra.
module game_lives_ctrl
  import game_pkg::*;
#(
  parameter int unsigned W             = 3,
  parameter int unsigned VIDAS_INI     = VIDAS_INI_DEF,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned INVULN_FRAMES = INVULN_FRAMES_DEF,
  parameter int unsigned PERDIO_FRAMES = PERDIO_FRAMES_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         juego_activo,
  input  logic         tick_frame,
  input  logic         impacto,
  input  logic         invasion,
  input  logic         vida_extra,
  output logic [W-1:0] vidas,
  output logic         invulnerable,
  output logic         perdio
);

  localparam logic [W-1:0]     VIDAS_MAX  = '1;
  localparam logic [W-1:0]     VIDAS_INIV = W'(VIDAS_INI);
  localparam logic [W-1:0]     VIDA_UNO   = W'(1);
  localparam logic [CNT_W-1:0] INV_LOAD   = CNT_W'(INVULN_FRAMES);
  localparam logic [CNT_W-1:0] PER_LOAD   = CNT_W'(PERDIO_FRAMES);

  state_e           state_q, state_d;
  logic [W-1:0]     vidas_q, vidas_d;
  logic             inv_q, perdio_q;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_done;
  logic             extra;

`ifdef VIDA_EXTRA_EN
  assign extra = vida_extra;
`else
  logic unused_vida_extra;
  assign unused_vida_extra = vida_extra;
  assign extra = 1'b0;
`endif

  frame_down_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .tick_i     (tick_frame),
    .done_o     (cnt_done)
  );

  always_comb begin
    state_d      = state_q;
    vidas_d      = vidas_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    unique case (state_q)
      IDLE: begin
        vidas_d = VIDAS_INIV;
        if (juego_activo) state_d = JUGANDO;
      end
      JUGANDO: begin
        if (!juego_activo) begin
          state_d = IDLE;
          vidas_d = VIDAS_INIV;
        end else if (invasion || (impacto && (vidas_q <= VIDA_UNO))) begin
          state_d      = PERDIDO;
          vidas_d      = '0;
          cnt_load     = 1'b1;
          cnt_load_val = PER_LOAD;
        end else if (impacto) begin
          state_d      = INVULN;
          cnt_load     = 1'b1;
          cnt_load_val = INV_LOAD;
          // A coincident extra life cancels the lost one.
          vidas_d      = extra ? vidas_q : (vidas_q - VIDA_UNO);
        end else if (extra && (vidas_q != VIDAS_MAX)) begin
          vidas_d = vidas_q + VIDA_UNO;
        end
      end
      INVULN: begin
        if (!juego_activo) begin
          state_d = IDLE;
          vidas_d = VIDAS_INIV;
        end else if (invasion) begin
          state_d      = PERDIDO;
          vidas_d      = '0;
          cnt_load     = 1'b1;
          cnt_load_val = PER_LOAD;
        end else begin
          if (extra && (vidas_q != VIDAS_MAX)) vidas_d = vidas_q + VIDA_UNO;
          if (cnt_done) state_d = JUGANDO;
        end
      end
      PERDIDO: begin
        if (cnt_done) state_d = FIN;
      end
      FIN: begin
        // Only a falling run level leaves FIN, so a stale high level cannot restart play.
        if (!juego_activo) begin
          state_d = IDLE;
          vidas_d = VIDAS_INIV;
        end
      end
      default: begin
        state_d = IDLE;
        vidas_d = VIDAS_INIV;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      vidas_q  <= VIDAS_INIV;
      inv_q    <= 1'b0;
      perdio_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vidas_q  <= vidas_d;
      inv_q    <= (state_d == INVULN);
      perdio_q <= (state_d == PERDIDO);
    end
  end

  assign vidas        = vidas_q;
  assign invulnerable = inv_q;
  assign perdio       = perdio_q;

endmodule

// File: tb/tb_game_lives_ctrl.sv
module tb_game_lives_ctrl;

  localparam int INI = 3;
  localparam int MAXV = 7;
  localparam int IFR = 60;
  localparam int PFR = 120;
`ifdef VIDA_EXTRA_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       juego_activo = 1'b0;
  logic       tick_frame = 1'b0;
  logic       impacto = 1'b0;
  logic       invasion = 1'b0;
  logic       vida_extra = 1'b0;
  logic [2:0] vidas;
  logic       invulnerable;
  logic       perdio;

  int checks = 0;
  int errors = 0;

  // Reference model: lives plus remaining frames of each window.
  int m_lives = INI;
  int m_inv   = 0;
  int m_loss  = 0;
  bit m_game  = 0;
  bit m_end   = 0;

  game_lives_ctrl #(
    .W(3), .VIDAS_INI(INI), .CNT_W(8), .INVULN_FRAMES(IFR), .PERDIO_FRAMES(PFR)
  ) dut (
    .CLK(CLK), .RST(RST), .juego_activo(juego_activo), .tick_frame(tick_frame),
    .impacto(impacto), .invasion(invasion), .vida_extra(vida_extra),
    .vidas(vidas), .invulnerable(invulnerable), .perdio(perdio)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_update();
    bit ex;
    ex = EXT && vida_extra;
    if (RST) begin
      m_lives = INI; m_inv = 0; m_loss = 0; m_game = 0; m_end = 0;
    end else if (m_loss > 0) begin
      if (tick_frame) begin
        m_loss--;
        if (m_loss == 0) m_end = 1;
      end
    end else if (m_end) begin
      if (!juego_activo) begin m_end = 0; m_lives = INI; end
    end else if (!m_game) begin
      m_lives = INI;
      if (juego_activo) m_game = 1;
    end else if (!juego_activo) begin
      m_game = 0; m_inv = 0; m_lives = INI;
    end else if (invasion || (impacto && m_inv == 0 && m_lives <= 1)) begin
      m_lives = 0; m_inv = 0; m_loss = PFR; m_game = 0;
    end else if (impacto && m_inv == 0) begin
      if (!ex) m_lives = m_lives - 1;
      m_inv = IFR;
    end else begin
      if (ex && m_lives < MAXV) m_lives++;
      if (m_inv > 0 && tick_frame) m_inv--;
    end
  endfunction

  task automatic step(input bit ja, input bit tk, input bit im, input bit iv, input bit ex);
    juego_activo = ja; tick_frame = tk; impacto = im; invasion = iv; vida_extra = ex;
    model_update();
    @(posedge CLK);
    #1;
    chk("vidas", 32'(vidas), 32'(m_lives));
    chk("invulnerable", 32'(invulnerable), 32'(m_inv > 0));
    chk("perdio", 32'(perdio), 32'(m_loss > 0));
  endtask

  int cnt_hi;
  int exp_ev;

  initial begin
    // reset
    RST = 1'b1;
    step(0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1);
    chk("reset_vidas", 32'(vidas), 32'd3);
    chk("reset_perdio", 32'(perdio), 32'd0);
    RST = 1'b0;

    // three hits spaced by 61 ticks
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    chk("hit1_vidas", 32'(vidas), 32'd2);
    cnt_hi = int'(invulnerable);
    for (int i = 1; i <= 61; i++) begin
      step(1, 1, 0, 0, 0);
      cnt_hi += int'(invulnerable);
    end
    chk("inv_window1", 32'(cnt_hi), 32'd60);
    step(1, 0, 1, 0, 0);
    chk("hit2_vidas", 32'(vidas), 32'd1);
    cnt_hi = int'(invulnerable);
    for (int i = 1; i <= 61; i++) begin
      step(1, 1, (i == 10), 0, 0);
      cnt_hi += int'(invulnerable);
    end
    chk("inv_window2", 32'(cnt_hi), 32'd60);
    chk("ignored_hit_vidas", 32'(vidas), 32'd1);
    step(1, 0, 1, 0, 0);
    chk("hit3_vidas", 32'(vidas), 32'd0);
    chk("hit3_perdio", 32'(perdio), 32'd1);
    cnt_hi = int'(perdio);
    for (int i = 1; i <= 121; i++) begin
      step(1, 1, 0, 0, 0);
      cnt_hi += int'(perdio);
    end
    chk("perdio_window", 32'(cnt_hi), 32'd120);
    repeat (3) step(1, 1, 1, 1, 0);
    chk("fin_vidas", 32'(vidas), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("fin_idle_vidas", 32'(vidas), 32'd3);

    // invasion from full lives
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    chk("invasion_vidas", 32'(vidas), 32'd0);
    chk("invasion_perdio", 32'(perdio), 32'd1);
    repeat (121) step(1, 1, 0, 0, 0);
    chk("invasion_release", 32'(perdio), 32'd0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // impacto + invasion together with vidas=2
    step(1, 0, 1, 0, 0);
    repeat (60) step(1, 1, 0, 0, 0);
    chk("back_to_play", 32'(invulnerable), 32'd0);
    step(1, 0, 1, 1, 0);
    chk("both_vidas", 32'(vidas), 32'd0);
    chk("both_inv", 32'(invulnerable), 32'd0);
    chk("both_perdio", 32'(perdio), 32'd1);

    // reset while in PERDIDO
    repeat (5) step(1, 1, 0, 0, 0);
    RST = 1'b1;
    step(1, 1, 0, 0, 0);
    chk("rst_perdio", 32'(perdio), 32'd0);
    chk("rst_vidas", 32'(vidas), 32'd3);
    RST = 1'b0;

    // extra life coinciding with non-fatal hit, then saturation
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    repeat (60) step(1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 1);
    exp_ev = EXT ? 2 : 1;
    chk("extra_hit_vidas", 32'(vidas), 32'(exp_ev));
    chk("extra_hit_inv", 32'(invulnerable), 32'd1);
    repeat (60) step(1, 1, 0, 0, 0);
    repeat (7) step(1, 0, 0, 0, 1);
    exp_ev = EXT ? 7 : 1;
    chk("extra_sat_vidas", 32'(vidas), 32'(exp_ev));

    // randomized traffic against the model
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      RST = ($urandom_range(499) == 0);
      step(($urandom_range(199) != 0), ($urandom_range(1) == 0), ($urandom_range(19) == 0),
           ($urandom_range(149) == 0), ($urandom_range(14) == 0));
    end
    RST = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
